// File: rtl/frame_pkg.sv
// frame_pkg: shared state encoding, line levels and frame-length helper for the framed serial link
package frame_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  function automatic int frame_len(int data_w, int div, int parity_en);
    return (2 + data_w + parity_en) * div;
  endfunction
endpackage

// File: rtl/bit_timer.sv
// bit_timer: DIV-cycle counter with synchronous clear, tick on the last cycle of each bit
module bit_timer
  import frame_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(DIV - 1);
  always_ff @(posedge clk)
    if (!rst_n || clr) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/frame_tx.sv
// frame_tx: valid/ready word in, LSB-first start/data/even-parity/stop frame out on tx
module frame_tx
  import frame_pkg::*;
#(
  parameter int DATA_W    = 11,
  parameter int DIV       = 4,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);
  localparam int BW = $clog2(DATA_W + 1);
  state_t state, state_n;
  logic [DATA_W-1:0] sr;
  logic [BW-1:0] bit_cnt;
  logic par, tick, accept, last_bit;
  bit_timer #(.DIV(DIV)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state == IDLE),
    .tick(tick)
  );
  assign accept = in_valid && in_ready;
  assign last_bit = bit_cnt == BW'(DATA_W - 1);
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign done = state == STOP && tick;
  assign tx = state == START ? START_LEVEL : state == DATA ? sr[0] : state == PAR ? par : IDLE_LEVEL;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? START : IDLE;
      START:   state_n = tick ? DATA : START;
      DATA:    state_n = tick && last_bit ? (PARITY_EN != 0 ? PAR : STOP) : DATA;
      PAR:     state_n = tick ? STOP : PAR;
      STOP:    state_n = tick ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      bit_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == DATA && tick) bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
    end
  always_ff @(posedge clk)
    if (accept) begin
      sr <= in_data;
      par <= ^in_data;
    end else if (state == DATA && tick) sr <= sr >> 1;
endmodule

// File: tb/tb_frame_tx.sv
// tb_frame_tx: table-driven, scoreboarded cycle-exact check of two frame_tx configurations
module tb_frame_tx;
  import frame_pkg::*;
  typedef struct {
    int u;
    logic [10:0] d;
    logic par;
    logic [10:0] nxt;
    logic hold;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] valid;
  logic [10:0] data [2];
  wire [1:0] ready, tx, busy, done;
  int total = 0;
  int bad = 0;
  vec_t sbq[$];
  vec_t vecs[6];
  always #5 clk = ~clk;
  frame_tx #(.DATA_W(11), .DIV(4), .PARITY_EN(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(data[0]), .in_valid(valid[0]),
    .in_ready(ready[0]), .tx(tx[0]), .busy(busy[0]), .done(done[0])
  );
  frame_tx #(.DATA_W(11), .DIV(1), .PARITY_EN(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(data[1]), .in_valid(valid[1]),
    .in_ready(ready[1]), .tx(tx[1]), .busy(busy[1]), .done(done[1])
  );
  function automatic logic [3:0] st(int u);
    return {tx[u], done[u], busy[u], ready[u]};
  endfunction
  task automatic chk(string nm, logic [3:0] act, logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got={tx,done,busy,ready}=%b want=%b", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(vec_t v);
    data[v.u] = v.d;
    valid[v.u] = 1'b1;
    sbq.push_back(v);
  endtask
  task automatic watch(int u);
    vec_t e;
    logic [13:0] bits;
    int div, pe, f;
    chk($sformatf("u%0d pre_ready", u), {3'b000, ready[u]}, 4'b0001);
    step();
    e = sbq.pop_front();
    if (!e.hold) valid[u] = 1'b0;
    data[u] = e.nxt;
    div = u != 0 ? 1 : 4;
    pe = u != 0 ? 0 : 1;
    f = frame_len(11, div, pe);
    bits[0] = 1'b0;
    bits[11:1] = e.d;
    bits[12] = pe != 0 ? e.par : 1'b1;
    bits[13] = 1'b1;
    for (int j = 0; j < f; j++) begin
      chk($sformatf("u%0d d=%h j=%0d", u, e.d, j), st(u), {bits[j / div], j == f - 1, 1'b1, 1'b0});
      step();
    end
    chk($sformatf("u%0d d=%h idle_after", u, e.d), st(u), 4'b1001);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    vec_t e;
    vecs[0] = '{0, 11'h5A3, 1'b0, 11'h0F0, 1'b0};
    vecs[1] = '{0, 11'h001, 1'b1, 11'h7FE, 1'b0};
    vecs[2] = '{0, 11'h123, 1'b0, 11'h456, 1'b1};
    vecs[3] = '{0, 11'h456, 1'b1, 11'h000, 1'b0};
    vecs[4] = '{1, 11'h7FF, 1'b0, 11'h2C5, 1'b1};
    vecs[5] = '{1, 11'h2C5, 1'b0, 11'h000, 1'b0};
    rst_n = 1'b0;
    valid = 2'b10;
    data[0] = 11'h000;
    data[1] = 11'h7FF;
    repeat (3) step();
    chk("reset_a", st(0), 4'b1001);
    chk("reset_b_valid_held", st(1), 4'b1001);
    valid = 2'b00;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("idle_a %0d", i), st(0), 4'b1001);
      chk($sformatf("idle_b %0d", i), st(1), 4'b1001);
    end
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i]);
      watch(vecs[i].u);
    end
    data[0] = 11'h3C3;
    valid[0] = 1'b1;
    step();
    valid[0] = 1'b0;
    repeat (25) step();
    chk("mid_bit5", st(0), 4'b0010);
    rst_n = 1'b0;
    step();
    chk("rst_abort", st(0), 4'b1001);
    step();
    chk("rst_hold", st(0), 4'b1001);
    rst_n = 1'b1;
    step();
    chk("post_rst", st(0), 4'b1001);
    e = '{0, 11'h2AA, 1'b1, 11'h155, 1'b0};
    drive(e);
    watch(0);
    chk("sbq_empty", 4'(sbq.size()), 4'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
